einstein_irq_ctrl: RTL and testbench

//  Mode-2 interrupt controller for the Einstein non-CTC sources (keyboard, fire, ADC, V9938 on TC256).

---
 rtl/einstein_irq_ctrl.sv | 143 ++++++++++++++
 tb/tb_einstein_irq_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/einstein_irq_ctrl.sv
// Mode-2 interrupt controller for the Einstein non-CTC sources.
// It captures source edges, masks them, and sits below the CTC daisy chain in priority.
module einstein_irq_ctrl #(
  parameter int unsigned NSRC     = 4,
  parameter logic [7:0]  VEC_BASE = 8'h00
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic [NSRC-1:0] i_src_n,
  input  logic            i_mask_wr,
  input  logic [2:0]      i_mask_sel,
  input  logic            i_mask_din,
  input  logic            i_clr_wr,
  input  logic [NSRC-1:0] i_clr_bits,
  input  logic            i_m1_n,
  input  logic            i_iorq_n,
  input  logic            i_ctc_int_n,
  input  logic            i_ctc_ieo,
  output logic            o_int_n,
  output logic            o_vec_oe,
  output logic [7:0]      o_vec,
  output logic [NSRC-1:0] o_pending,
  output logic            o_ack
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_ACK    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [NSRC-1:0] r_src_prev;
  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] r_mask;
  logic            r_inta;
  logic            r_inta_prev;
  logic [2:0]      r_act;
  logic            r_rearm;
  logic            r_int_n;
  logic            r_vec_oe;
  logic [7:0]      r_vec;
  logic            r_ack;

  logic [NSRC-1:0] w_edge;
  logic [NSRC-1:0] w_elig;
  logic            w_any;
  logic            w_inta_rise;
  logic [2:0]      w_win;
  logic            w_act_edge;

  assign w_edge      = r_src_prev & ~i_src_n;
  assign w_elig      = r_pending & ~r_mask;
  assign w_any       = |w_elig;
  assign w_inta_rise = r_inta & ~r_inta_prev;

  // Lowest eligible index wins; the edge on the source being acknowledged is tracked separately.
  always_comb begin
    w_win      = 3'd0;
    w_act_edge = 1'b0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = 3'(i);
    end
    for (int i = 0; i < int'(NSRC); i++) begin
      if (r_act == 3'(i) && w_edge[i]) w_act_edge = 1'b1;
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any && i_ctc_ieo && i_ctc_int_n) w_nxt = S_ASSERT;
      S_ASSERT: begin
        if (w_inta_rise)                 w_nxt = S_ACK;
        else if (!w_any || !i_ctc_ieo)   w_nxt = S_IDLE;
      end
      S_ACK:    if (!r_inta) w_nxt = S_DONE;
      S_DONE:   w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  // Outputs follow the next state so they line up with the state they describe.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_int_n     <= 1'b1;
      r_vec_oe    <= 1'b0;
      r_vec       <= VEC_BASE;
      r_ack       <= 1'b0;
      r_act       <= 3'd0;
      r_rearm     <= 1'b0;
      r_inta      <= 1'b0;
      r_inta_prev <= 1'b0;
      r_src_prev  <= '0;
    end else begin
      r_int_n     <= ~(w_nxt == S_ASSERT || w_nxt == S_ACK) & i_ctc_int_n;
      r_vec_oe    <= (w_nxt == S_ACK);
      r_ack       <= (w_nxt == S_DONE);
      r_inta      <= ~i_m1_n & ~i_iorq_n;
      r_inta_prev <= r_inta;
      r_src_prev  <= i_src_n;
      if (r_state == S_ASSERT && w_nxt == S_ACK) begin
        r_vec <= VEC_BASE | 8'({w_win, 1'b0});
        r_act <= w_win;
      end
      if (r_state == S_IDLE)               r_rearm <= 1'b0;
      else if (r_state == S_ACK && w_act_edge) r_rearm <= 1'b1;
    end
  end

  // A fresh edge beats the acknowledge clear, which in turn beats a software clear.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      r_mask    <= '1;
    end else begin
      for (int i = 0; i < int'(NSRC); i++) begin
        if (w_edge[i])
          r_pending[i] <= 1'b1;
        else if (r_state == S_DONE && r_act == 3'(i) && !r_rearm)
          r_pending[i] <= 1'b0;
        else if (i_clr_wr && i_clr_bits[i])
          r_pending[i] <= 1'b0;
        if (i_mask_wr && i_mask_sel == 3'(i))
          r_mask[i] <= i_mask_din;
      end
    end
  end

  assign o_int_n   = r_int_n;
  assign o_vec_oe  = r_vec_oe;
  assign o_vec     = r_vec;
  assign o_pending = r_pending;
  assign o_ack     = r_ack;

endmodule

// File: tb/tb_einstein_irq_ctrl.sv
// Directed bench for einstein_irq_ctrl: edge capture, priority, CTC gating, masking, re-arm and reset.
module tb_einstein_irq_ctrl;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [3:0] src_n;
  logic       mask_wr;
  logic [2:0] mask_sel;
  logic       mask_din;
  logic       clr_wr;
  logic [3:0] clr_bits;
  logic       m1_n;
  logic       iorq_n;
  logic       ctc_int_n;
  logic       ctc_ieo;
  logic       int_n;
  logic       vec_oe;
  logic [7:0] vec;
  logic [3:0] pending;
  logic       ack;

  int n_checks = 0;
  int n_errors = 0;

  einstein_irq_ctrl #(.NSRC(4), .VEC_BASE(8'h00)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .i_src_n     (src_n),
    .i_mask_wr   (mask_wr),
    .i_mask_sel  (mask_sel),
    .i_mask_din  (mask_din),
    .i_clr_wr    (clr_wr),
    .i_clr_bits  (clr_bits),
    .i_m1_n      (m1_n),
    .i_iorq_n    (iorq_n),
    .i_ctc_int_n (ctc_int_n),
    .i_ctc_ieo   (ctc_ieo),
    .o_int_n     (int_n),
    .o_vec_oe    (vec_oe),
    .o_vec       (vec),
    .o_pending   (pending),
    .o_ack       (ack)
  );

  always #15 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic write_mask(input logic [2:0] sel, input logic din);
    mask_wr = 1'b1; mask_sel = sel; mask_din = din;
    step();
    mask_wr = 1'b0;
  endtask

  task automatic pulse_src(input logic [3:0] low_bits);
    src_n = ~low_bits;
    step();
    src_n = 4'hF;
    step();
  endtask

  // Full INTA: hold for three clocks, release, then watch for the acknowledge.
  task automatic run_inta(output logic oe_seen, output logic [7:0] v, output int acks);
    oe_seen = 1'b0; v = 8'h00; acks = 0;
    m1_n = 1'b0; iorq_n = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) begin m1_n = 1'b1; iorq_n = 1'b1; end
      step();
      if (vec_oe && !oe_seen) begin oe_seen = 1'b1; v = vec; end
      if (ack) acks++;
    end
  endtask

  logic       oe_seen;
  logic [7:0] v;
  int         acks;

  initial begin
    reset = 1'b1; src_n = 4'hF; mask_wr = 1'b0; mask_sel = 3'd0; mask_din = 1'b0;
    clr_wr = 1'b0; clr_bits = 4'h0; m1_n = 1'b1; iorq_n = 1'b1;
    ctc_int_n = 1'b1; ctc_ieo = 1'b1;
    step(3);
    reset = 1'b0;
    step();
    check("rst_int_n", int_n, 1'b1);
    check("rst_vec_oe", vec_oe, 1'b0);
    check("rst_vec", vec, 8'h00);
    check("rst_pending", pending, 4'h0);
    check("rst_ack", ack, 1'b0);

    // Single source, full INTA
    write_mask(3'd1, 1'b0);
    src_n = 4'b1101;
    step();
    check("t1_capture", pending, 4'b0010);
    src_n = 4'hF;
    step();
    check("t1_int_n_low", int_n, 1'b0);
    run_inta(oe_seen, v, acks);
    check("t1_vec_oe", oe_seen, 1'b1);
    check("t1_vec", v, 8'h02);
    check("t1_ack_once", acks, 1);
    check("t1_pending_clr", pending, 4'h0);
    check("t1_int_n_high", int_n, 1'b1);

    // Simultaneous edges: priority order
    write_mask(3'd0, 1'b0);
    write_mask(3'd2, 1'b0);
    pulse_src(4'b0101);
    check("t2_pending", pending, 4'b0101);
    run_inta(oe_seen, v, acks);
    check("t2_vec_first", v, 8'h00);
    check("t2_pending_mid", pending, 4'b0100);
    run_inta(oe_seen, v, acks);
    check("t2_vec_second", v, 8'h04);
    check("t2_pending_end", pending, 4'h0);

    // CTC owns the bus, then releases it
    ctc_int_n = 1'b0; ctc_ieo = 1'b0;
    pulse_src(4'b0001);
    step();
    check("t3_pending", pending, 4'b0001);
    check("t3_int_n_ctc", int_n, 1'b0);
    run_inta(oe_seen, v, acks);
    check("t3_no_vec_oe", oe_seen, 1'b0);
    check("t3_no_ack", acks, 0);
    check("t3_pending_kept", pending, 4'b0001);
    ctc_int_n = 1'b1; ctc_ieo = 1'b1;
    step(2);
    check("t3_int_n_own", int_n, 1'b0);
    run_inta(oe_seen, v, acks);
    check("t3_vec", v, 8'h00);
    check("t3_ack", acks, 1);

    // Masking during ASSERT
    write_mask(3'd3, 1'b0);
    pulse_src(4'b1000);
    check("t4_int_n_low", int_n, 1'b0);
    write_mask(3'd3, 1'b1);
    step();
    check("t4_int_n_masked", int_n, 1'b1);
    check("t4_pending_kept", pending, 4'b1000);
    write_mask(3'd3, 1'b0);
    step();
    check("t4_int_n_reassert", int_n, 1'b0);
    run_inta(oe_seen, v, acks);
    check("t4_vec", v, 8'h06);
    check("t4_pending_clr", pending, 4'h0);

    // Software clear; a held-low level does not re-set
    write_mask(3'd3, 1'b1);
    src_n = 4'b0111;
    step();
    check("t4c_pending", pending, 4'b1000);
    check("t4c_int_n", int_n, 1'b1);
    clr_wr = 1'b1; clr_bits = 4'b1000;
    step();
    clr_wr = 1'b0; clr_bits = 4'h0;
    step(2);
    check("t4c_cleared_level", pending, 4'h0);
    src_n = 4'hF;
    step();

    // New edge on the acknowledged source during ACK
    pulse_src(4'b0010);
    m1_n = 1'b0; iorq_n = 1'b0;
    step(2);
    check("t5_vec_oe", vec_oe, 1'b1);
    check("t5_vec", vec, 8'h02);
    pulse_src(4'b0010);
    m1_n = 1'b1; iorq_n = 1'b1;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (ack) acks++;
    end
    check("t5_ack", acks, 1);
    check("t5_pending_rearm", pending, 4'b0010);
    check("t5_int_n_reassert", int_n, 1'b0);
    run_inta(oe_seen, v, acks);
    check("t5_vec_second", v, 8'h02);
    check("t5_pending_end", pending, 4'h0);

    // Asynchronous reset in the middle of ACK
    pulse_src(4'b0100);
    m1_n = 1'b0; iorq_n = 1'b0;
    step(2);
    check("t6_vec_oe", vec_oe, 1'b1);
    check("t6_vec", vec, 8'h04);
    #5;
    reset = 1'b1;
    #1;
    check("t6_vec_oe_async", vec_oe, 1'b0);
    check("t6_int_n", int_n, 1'b1);
    check("t6_pending", pending, 4'h0);
    check("t6_vec_base", vec, 8'h00);
    m1_n = 1'b1; iorq_n = 1'b1;
    step(2);
    reset = 1'b0;
    step();
    pulse_src(4'hF);
    step();
    check("t6_pending_all", pending, 4'hF);
    check("t6_masked_int_n", int_n, 1'b1);
    write_mask(3'd4, 1'b0);
    step(2);
    check("t6_sel_oob", int_n, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
